// File: rtl/divisor_sequencial_if.sv
// divisor_sequencial_if
//   Handshake and data bundle for the sequential restoring divider.
//   master : requester side (drives St and operands, observes results)
//   slave  : divider side   (samples St and operands, drives results)
//   Signals:
//     St        start request, level-sampled while the divider is idle
//     Dividendo 2N-bit unsigned dividend
//     Divisor   N-bit unsigned divisor
//     Done      one-cycle pulse, result/Ovf valid
//     Idle      divider ready to accept St
//     Quociente N-bit quotient
//     Resto     N-bit remainder
//     Ovf       overflow / divide-by-zero flag
interface divisor_sequencial_if #(
  parameter int N = 16
);
  logic           St;
  logic [2*N-1:0] Dividendo;
  logic [N-1:0]   Divisor;
  logic           Done;
  logic           Idle;
  logic [N-1:0]   Quociente;
  logic [N-1:0]   Resto;
  logic           Ovf;

  modport master (
    output St, Dividendo, Divisor,
    input  Done, Idle, Quociente, Resto, Ovf
  );

  modport slave (
    input  St, Dividendo, Divisor,
    output Done, Idle, Quociente, Resto, Ovf
  );
endinterface

// File: rtl/divisor_sequencial.sv
// divisor_sequencial
//   Sequential restoring divider: 2N-bit unsigned dividend / N-bit unsigned
//   divisor -> N-bit quotient and N-bit remainder, one quotient bit per clock.
//   Overflow (quotient would not fit in N bits) and divide-by-zero are caught
//   in a single check cycle before any iteration is spent.
//   Ports:
//     Clk  system clock, all state changes on the rising edge
//     Rst  synchronous active-high reset, highest priority
//     bus  divisor_sequencial_if.slave (St/Done/Idle handshake, operands,
//          registered Quociente/Resto/Ovf)
module divisor_sequencial #(
  parameter int N = 16
) (
  input logic                 Clk,
  input logic                 Rst,
  divisor_sequencial_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ITER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [2*N:0]  acc;
  logic [2*N:0]  acc_shift;
  logic [2*N:0]  acc_step;
  logic [N:0]    acc_hi_sub;
  logic [N-1:0]  dreg;
  logic [CW-1:0] cnt;
  logic          check_ovf;
  logic          last_iter;

  // Early-termination test: the quotient only fits in N bits when the upper
  // half of the dividend is strictly below the divisor.
  always_comb begin
    check_ovf = (dreg == {N{1'b0}}) || (acc[2*N-1:N] >= dreg);
    last_iter = (cnt == CNT_LAST);
  end

  // One restoring step. The partial remainder is compared on N+1 bits so the
  // bit shifted out of the N-bit window still takes part in the comparison.
  always_comb begin
    acc_shift  = acc << 1;
    acc_hi_sub = acc_shift[2*N:N] - {1'b0, dreg};
    if (acc_shift[2*N:N] >= {1'b0, dreg}) begin
      acc_step = {acc_hi_sub, acc_shift[N-1:1], 1'b1};
    end else begin
      acc_step = acc_shift;
    end
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.St) begin
          state_next = CHECK;
        end else begin
          state_next = IDLE;
        end
      end
      CHECK: begin
        if (check_ovf) begin
          state_next = DONE;
        end else begin
          state_next = ITER;
        end
      end
      ITER: begin
        if (last_iter) begin
          state_next = DONE;
        end else begin
          state_next = ITER;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: pure decodes of the state register.
  always_comb begin
    bus.Idle = (state == IDLE);
    bus.Done = (state == DONE);
  end

  // Datapath: operand latch, iteration, result registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc           <= {(2*N+1){1'b0}};
      dreg          <= {N{1'b0}};
      cnt           <= {CW{1'b0}};
      bus.Quociente <= {N{1'b0}};
      bus.Resto     <= {N{1'b0}};
      bus.Ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.St) begin
            acc     <= {1'b0, bus.Dividendo};
            dreg    <= bus.Divisor;
            bus.Ovf <= 1'b0;
          end
        end
        CHECK: begin
          // On overflow the previous quotient/remainder are kept on purpose.
          if (check_ovf) begin
            bus.Ovf <= 1'b1;
          end else begin
            cnt <= {CW{1'b0}};
          end
        end
        ITER: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
          if (last_iter) begin
            bus.Quociente <= acc_step[N-1:0];
            bus.Resto     <= acc_step[2*N-1:N];
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

endmodule
